phys_reg_freelist: RTL and testbench



---
 rtl/phys_reg_freelist.sv | 99 +++++++++
 tb/tb_phys_reg_freelist.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/phys_reg_freelist.sv
// phys_reg_freelist: circular free list of physical register tags, multi-slot alloc and release per cycle
// The queue depth is not a power of two, so every pointer advance goes through an explicit modulo compare.
module phys_reg_freelist #(
    parameter int DISPATCH_WIDTH = 2,
    parameter int PHYS_REGS = 128,
    parameter int ARCH_REGS = 32,
    localparam int TAG_W = $clog2(PHYS_REGS),
    localparam int FREE_SIZE = PHYS_REGS - ARCH_REGS,
    localparam int CNT_W = $clog2(FREE_SIZE + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DISPATCH_WIDTH-1:0]       alloc_req,
    output logic                            alloc_ready,
    output logic [DISPATCH_WIDTH*TAG_W-1:0] alloc_tag,
    input  logic [DISPATCH_WIDTH-1:0]       release_valid,
    input  logic [DISPATCH_WIDTH*TAG_W-1:0] release_tag,
    output logic [CNT_W-1:0]                free_count,
    output logic                            empty,
    output logic                            overflow_err
);
    localparam int PTR_W = $clog2(FREE_SIZE);

    logic [TAG_W-1:0] queue_q [FREE_SIZE];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] nalloc, nfired, nrel, space;
    logic             fire;
    logic [DISPATCH_WIDTH-1:0] wr_en;
    logic [PTR_W-1:0] wr_ptr [DISPATCH_WIDTH];

    function automatic logic [PTR_W-1:0] wrap(input logic [PTR_W-1:0] p, input logic [CNT_W-1:0] n);
        int s;
        s = int'(p) + int'(n);
        return PTR_W'(s >= FREE_SIZE ? s - FREE_SIZE : s);
    endfunction

    // Requests are compacted: the k-th asserted slot takes the k-th tag from head.
    always_comb begin
        nalloc = '0;
        alloc_tag = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            if (alloc_req[i]) begin
                alloc_tag[i*TAG_W +: TAG_W] = queue_q[wrap(head_q, nalloc)];
                nalloc = nalloc + CNT_W'(1);
            end
        end
    end

    assign alloc_ready = count_q >= nalloc;
    assign fire = alloc_ready && |alloc_req;
    assign nfired = fire ? nalloc : '0;
    assign space = CNT_W'(FREE_SIZE) - count_q + nfired;

    // Releases beyond the free space are dropped and flagged; tag 0 is never queued.
    always_comb begin
        nrel = '0;
        ovf_d = 1'b0;
        wr_en = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            wr_ptr[i] = '0;
            if (release_valid[i] && release_tag[i*TAG_W +: TAG_W] != '0) begin
                if (nrel < space) begin
                    wr_en[i] = 1'b1;
                    wr_ptr[i] = wrap(tail_q, nrel);
                    nrel = nrel + CNT_W'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    assign head_d = wrap(head_q, nfired);
    assign tail_d = wrap(tail_q, nrel);
    assign count_d = count_q - nfired + nrel;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FREE_SIZE; i++) queue_q[i] <= TAG_W'(ARCH_REGS + i);
            head_q <= '0;
            tail_q <= '0;
            count_q <= CNT_W'(FREE_SIZE);
            ovf_q <= 1'b0;
        end else begin
            for (int i = 0; i < DISPATCH_WIDTH; i++)
                if (wr_en[i]) queue_q[wr_ptr[i]] <= release_tag[i*TAG_W +: TAG_W];
            head_q <= head_d;
            tail_q <= tail_d;
            count_q <= count_d;
            ovf_q <= ovf_q | ovf_d;
        end
    end

    assign free_count = count_q;
    assign empty = count_q == '0;
    assign overflow_err = ovf_q;
endmodule

// File: tb/tb_phys_reg_freelist.sv
// tb_phys_reg_freelist: directed scenario tasks with hand-computed tags and counts
module tb_phys_reg_freelist;
    logic        clk = 0;
    logic        rst = 0;
    logic [1:0]  alloc_req = '0;
    logic        alloc_ready;
    logic [13:0] alloc_tag;
    logic [1:0]  release_valid = '0;
    logic [13:0] release_tag = '0;
    logic [6:0]  free_count;
    logic        empty;
    logic        overflow_err;
    logic [6:0]  t0, t1;
    int checks = 0;
    int fails = 0;

    assign t0 = alloc_tag[6:0];
    assign t1 = alloc_tag[13:7];

    phys_reg_freelist dut (
        .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_ready(alloc_ready),
        .alloc_tag(alloc_tag), .release_valid(release_valid), .release_tag(release_tag),
        .free_count(free_count), .empty(empty), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        alloc_req = '0;
        release_valid = '0;
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (free_count !== 7'd96) begin fails++; $display("FAIL reset_count got %0d want 96", free_count); end
        checks++; if (empty !== 1'b0) begin fails++; $display("FAIL reset_empty got %b want 0", empty); end
        checks++; if (overflow_err !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", overflow_err); end
        checks++; if (alloc_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", alloc_ready); end
    endtask

    task automatic test_dual_alloc();
        do_reset();
        alloc_req = 2'b11;
        #1;
        checks++; if (t0 !== 7'd32 || t1 !== 7'd33 || alloc_ready !== 1'b1) begin fails++; $display("FAIL dual_first got %0d,%0d rdy %b want 32,33 rdy 1", t0, t1, alloc_ready); end
        tick();
        checks++; if (free_count !== 7'd94) begin fails++; $display("FAIL dual_count1 got %0d want 94", free_count); end
        checks++; if (t0 !== 7'd34 || t1 !== 7'd35) begin fails++; $display("FAIL dual_second got %0d,%0d want 34,35", t0, t1); end
        tick();
        alloc_req = '0;
        checks++; if (free_count !== 7'd92) begin fails++; $display("FAIL dual_count2 got %0d want 92", free_count); end
    endtask

    task automatic test_partial();
        do_reset();
        alloc_req = 2'b10;
        #1;
        checks++; if (t1 !== 7'd32 || t0 !== 7'd0) begin fails++; $display("FAIL partial_hi got %0d,%0d want 32,0", t1, t0); end
        tick();
        checks++; if (free_count !== 7'd95) begin fails++; $display("FAIL partial_count got %0d want 95", free_count); end
        alloc_req = 2'b01;
        #1;
        checks++; if (t0 !== 7'd33 || t1 !== 7'd0) begin fails++; $display("FAIL partial_lo got %0d,%0d want 33,0", t0, t1); end
        tick();
        alloc_req = '0;
    endtask

    task automatic test_drain_and_refill();
        do_reset();
        for (int j = 0; j < 47; j++) begin
            alloc_req = 2'b11;
            #1;
            checks++; if (t0 !== 7'(32 + 2*j) || t1 !== 7'(33 + 2*j)) begin fails++; $display("FAIL drain_tag%0d got %0d,%0d want %0d,%0d", j, t0, t1, 32 + 2*j, 33 + 2*j); end
            tick();
        end
        alloc_req = 2'b01;
        tick();
        checks++; if (free_count !== 7'd1) begin fails++; $display("FAIL drain_count got %0d want 1", free_count); end
        alloc_req = 2'b11;
        for (int j = 0; j < 3; j++) begin
            #1;
            checks++; if (alloc_ready !== 1'b0) begin fails++; $display("FAIL short_ready got %b want 0", alloc_ready); end
            tick();
            checks++; if (free_count !== 7'd1) begin fails++; $display("FAIL short_hold got %0d want 1", free_count); end
        end
        alloc_req = 2'b01;
        #1;
        checks++; if (t0 !== 7'd127 || alloc_ready !== 1'b1) begin fails++; $display("FAIL last_tag got %0d rdy %b want 127 rdy 1", t0, alloc_ready); end
        tick();
        checks++; if (free_count !== 7'd0 || empty !== 1'b1) begin fails++; $display("FAIL empty got cnt %0d empty %b want 0,1", free_count, empty); end
        release_valid = 2'b11;
        release_tag = {7'd7, 7'd5};
        #1;
        checks++; if (alloc_ready !== 1'b0) begin fails++; $display("FAIL no_bypass got %b want 0", alloc_ready); end
        tick();
        release_valid = '0;
        checks++; if (free_count !== 7'd2) begin fails++; $display("FAIL refill_count got %0d want 2", free_count); end
        alloc_req = 2'b11;
        #1;
        checks++; if (t0 !== 7'd5 || t1 !== 7'd7 || alloc_ready !== 1'b1) begin fails++; $display("FAIL refill_tags got %0d,%0d rdy %b want 5,7 rdy 1", t0, t1, alloc_ready); end
        tick();
        alloc_req = '0;
        checks++; if (free_count !== 7'd0 || empty !== 1'b1) begin fails++; $display("FAIL refill_empty got %0d,%b want 0,1", free_count, empty); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 95; i++) begin
            alloc_req = 2'b01;
            release_valid = 2'b01;
            release_tag = {7'd0, 7'(32 + i)};
            #1;
            checks++; if (t0 !== 7'(32 + i)) begin fails++; $display("FAIL recycle%0d got %0d want %0d", i, t0, 32 + i); end
            tick();
        end
        checks++; if (free_count !== 7'd96) begin fails++; $display("FAIL recycle_count got %0d want 96", free_count); end
        alloc_req = 2'b11;
        release_valid = 2'b11;
        release_tag = {7'd101, 7'd100};
        #1;
        checks++; if (t0 !== 7'd127 || t1 !== 7'd32) begin fails++; $display("FAIL wrap_tags got %0d,%0d want 127,32", t0, t1); end
        tick();
        release_valid = '0;
        checks++; if (free_count !== 7'd96 || overflow_err !== 1'b0) begin fails++; $display("FAIL wrap_count got %0d ovf %b want 96,0", free_count, overflow_err); end
        for (int j = 0; j < 47; j++) begin
            #1;
            checks++; if (t0 !== 7'(33 + 2*j) || t1 !== 7'(34 + 2*j)) begin fails++; $display("FAIL walk%0d got %0d,%0d want %0d,%0d", j, t0, t1, 33 + 2*j, 34 + 2*j); end
            tick();
        end
        checks++; if (free_count !== 7'd2) begin fails++; $display("FAIL walk_count got %0d want 2", free_count); end
        #1;
        checks++; if (t0 !== 7'd100 || t1 !== 7'd101) begin fails++; $display("FAIL wrap_release got %0d,%0d want 100,101", t0, t1); end
        tick();
        alloc_req = '0;
        checks++; if (empty !== 1'b1) begin fails++; $display("FAIL wrap_empty got %b want 1", empty); end
    endtask

    task automatic test_overflow_and_reset();
        do_reset();
        alloc_req = 2'b01;
        tick();
        alloc_req = '0;
        release_valid = 2'b11;
        release_tag = {7'd40, 7'd0};
        tick();
        checks++; if (free_count !== 7'd96 || overflow_err !== 1'b0) begin fails++; $display("FAIL tag0_ignored got %0d ovf %b want 96,0", free_count, overflow_err); end
        release_valid = 2'b01;
        release_tag = {7'd0, 7'd41};
        tick();
        release_valid = '0;
        checks++; if (free_count !== 7'd96 || overflow_err !== 1'b1) begin fails++; $display("FAIL overflow got %0d ovf %b want 96,1", free_count, overflow_err); end
        tick();
        checks++; if (overflow_err !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b want 1", overflow_err); end
        alloc_req = 2'b11;
        #1;
        checks++; if (t0 !== 7'd33 || t1 !== 7'd34) begin fails++; $display("FAIL post_ovf_tags got %0d,%0d want 33,34", t0, t1); end
        tick();
        checks++; if (free_count !== 7'd94) begin fails++; $display("FAIL post_ovf_count got %0d want 94", free_count); end
        rst = 1;
        release_valid = 2'b11;
        release_tag = {7'd9, 7'd8};
        tick();
        rst = 0;
        release_valid = '0;
        #1;
        checks++; if (free_count !== 7'd96 || overflow_err !== 1'b0 || empty !== 1'b0) begin fails++; $display("FAIL midreset got %0d ovf %b empty %b want 96,0,0", free_count, overflow_err, empty); end
        checks++; if (t0 !== 7'd32 || t1 !== 7'd33) begin fails++; $display("FAIL midreset_tags got %0d,%0d want 32,33", t0, t1); end
        alloc_req = '0;
    endtask

    initial begin
        test_reset();
        test_dual_alloc();
        test_partial();
        test_drain_and_refill();
        test_wrap();
        test_overflow_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
